fixed_latency_multiplier: RTL and testbench



---
 rtl/multi_pkg.sv | 26 ++
 rtl/fixed_latency_multiplier_booth_step.sv | 56 +++++
 rtl/fixed_latency_multiplier.sv | 108 ++++++++++
 tb/tb_fixed_latency_multiplier.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/multi_pkg.sv
// Shared types and constants for the fixed-latency Booth multiplier.
// Build option MULTI_RADIX4_EN selects radix-4 recoding (2 bits per step) instead of radix-2.
package multi_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

`ifdef MULTI_RADIX4_EN
  localparam int BITS_PER_STEP = 2;
  localparam int GUARD_BITS    = 2;
`else
  localparam int BITS_PER_STEP = 1;
  localparam int GUARD_BITS    = 1;
`endif

  // Cycles from accepted start to valid: one per Booth step plus the DONE cycle.
  function automatic int multi_latency(input int width);
    return width / BITS_PER_STEP + 1;
  endfunction

endpackage

// File: rtl/fixed_latency_multiplier_booth_step.sv
// One combinational Booth iteration on {acc, q, q_1}: recode, add/sub, arithmetic shift.
// MULTI_RADIX4_EN selects modified (radix-4) recoding with digits {0, +-m, +-2m}.
module booth_step
  import multi_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = WIDTH + GUARD_BITS
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic        [WIDTH-1:0] i_q,
  input  logic                    i_q_1,
  input  logic signed [WIDTH-1:0] i_m,
  output logic signed [ACC_W-1:0] o_acc,
  output logic        [WIDTH-1:0] o_q,
  output logic                    o_q_1
);

  localparam int G = ACC_W - WIDTH;

  logic signed [ACC_W-1:0]       w_m_ext;
  logic signed [ACC_W-1:0]       w_sum;
  logic signed [ACC_W+WIDTH:0]   w_cat;
  logic signed [ACC_W+WIDTH:0]   w_shift;

  assign w_m_ext = {{G{i_m[WIDTH-1]}}, i_m};

`ifdef MULTI_RADIX4_EN
  always_comb begin
    w_sum = i_acc;
    unique case ({i_q[1], i_q[0], i_q_1})
      3'b001, 3'b010: w_sum = i_acc + w_m_ext;
      3'b011:         w_sum = i_acc + (w_m_ext <<< 1);
      3'b100:         w_sum = i_acc - (w_m_ext <<< 1);
      3'b101, 3'b110: w_sum = i_acc - w_m_ext;
      default:        w_sum = i_acc;
    endcase
  end
`else
  always_comb begin
    w_sum = i_acc;
    unique case ({i_q[0], i_q_1})
      2'b01:   w_sum = i_acc + w_m_ext;
      2'b10:   w_sum = i_acc - w_m_ext;
      default: w_sum = i_acc;
    endcase
  end
`endif

  assign w_cat   = {w_sum, i_q, i_q_1};
  assign w_shift = w_cat >>> BITS_PER_STEP;

  assign o_acc = w_shift[ACC_W+WIDTH:WIDTH+1];
  assign o_q   = w_shift[WIDTH:1];
  assign o_q_1 = w_shift[0];

endmodule

// File: rtl/fixed_latency_multiplier.sv
// Signed WIDTH x WIDTH multiplier with data-independent latency (iterative Booth).
// Define MULTI_RADIX4_EN for radix-4 steps (latency WIDTH/2+1) instead of radix-2 (WIDTH+1).
module fixed_latency_multiplier
  import multi_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [WIDTH-1:0]   mlier,
  input  logic signed [WIDTH-1:0]   mcand,
  input  logic                      start,
  output logic signed [2*WIDTH-1:0] prodt,
  output logic                      valid
);

  localparam int LATENCY = multi_latency(WIDTH);
  localparam int STEPS   = LATENCY - 1;
  localparam int ACC_W   = WIDTH + GUARD_BITS;
  localparam int CNT_W   = $clog2(STEPS + 1);

  state_t                   r_state;
  state_t                   w_state_nx;
  logic                     r_start_q;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [WIDTH-1:0]  r_q;
  logic                     r_q_1;
  logic signed [WIDTH-1:0]  r_m;
  logic        [CNT_W-1:0]  r_cnt;

  logic signed [ACC_W-1:0]  w_acc_nx;
  logic        [WIDTH-1:0]  w_q_nx;
  logic                     w_q_1_nx;
  logic                     w_accept;
  logic                     w_last;

  assign w_accept = start && !r_start_q && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(STEPS - 1));

  booth_step #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_booth_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_acc (w_acc_nx),
    .o_q   (w_q_nx),
    .o_q_1 (w_q_1_nx)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nx = BUSY;
      BUSY:    if (w_last)   w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // prodt is only cleared on a new accept, so a finished result stays visible while idle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_start_q <= 1'b0;
      r_acc     <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      prodt     <= '0;
      valid     <= 1'b0;
    end else begin
      r_start_q <= start;
      valid     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= '0;
            r_q   <= mlier;
            r_q_1 <= 1'b0;
            r_m   <= mcand;
            r_cnt <= '0;
            prodt <= '0;
          end
        end
        BUSY: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          r_q_1 <= w_q_1_nx;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          prodt <= {r_acc[WIDTH-1:0], r_q};
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_latency_multiplier.sv
// Scoreboard bench for fixed_latency_multiplier; honours MULTI_RADIX4_EN for the expected latency.
module tb_fixed_latency_multiplier;

`ifdef MULTI_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic signed [31:0] mlier = '0;
  logic signed [31:0] mcand = '0;
  logic signed [63:0] prodt;
  logic               valid;

  fixed_latency_multiplier dut (
    .clock (clock),
    .reset (reset),
    .mlier (mlier),
    .mcand (mcand),
    .prodt (prodt),
    .start (start),
    .valid (valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    longint prod;
    int     cyc;
    string  name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk64(input string name, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding operation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: valid high at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk64({e.name, "_prodt"}, prodt, e.prod);
        chk64({e.name, "_latency"}, longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic issue(input string name, input int a, input int b, input longint want);
    exp_t e;
    @(negedge clock);
    mlier = a;
    mcand = b;
    start = 1'b1;
    e.prod = want;
    e.cyc  = cyc + 1 + LAT;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input longint want);
    int n = 0;
    while (sb.size() != 0 && n < LAT + 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding after %0d cycles, expected 0",
               name, sb.size(), n);
      sb.delete();
    end
    repeat (3) @(negedge clock);
    chk64({name, "_hold"}, prodt, want);
  endtask

  task automatic run_op(input string name, input int a, input int b, input longint want);
    issue(name, a, b, want);
    @(negedge clock);
    mlier = $urandom;
    mcand = $urandom;
    repeat (LAT - 1) @(negedge clock);
    start = 1'b0;
    drain(name, want);
  endtask

  initial begin
    int     a;
    int     b;
    int     min_i;
    int     max_i;
    min_i = 32'h8000_0000;
    max_i = 32'h7fff_ffff;

    repeat (3) @(negedge clock);
    chk64("reset_prodt", prodt, 0);
    chk64("reset_valid", longint'(valid), 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk64("idle_prodt", prodt, 0);
    chk64("idle_valid", longint'(valid), 0);

    run_op("mul_7_m3", 7, -3, -21);
    run_op("min_x_min", min_i, min_i, 64'sh4000_0000_0000_0000);
    run_op("min_x_max", min_i, max_i, -64'sd4611686016279904256);
    run_op("zero_x_m1", 0, -1, 0);
    run_op("m1_x_m1", -1, -1, 1);

    // A second rising edge on start while busy must be ignored.
    issue("retoggle", 1234, -5678, -7006652);
    repeat (5) @(negedge clock);
    start = 1'b0;
    mlier = 99;
    mcand = 99;
    @(negedge clock);
    start = 1'b1;
    repeat (5) @(negedge clock);
    start = 1'b0;
    drain("retoggle", -7006652);

    // Reset mid-operation: no pulse for the aborted op, prodt cleared.
    issue("abort", 1000, 1000, 1000000);
    repeat (10) @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    sb.delete();
    repeat (2) @(negedge clock);
    chk64("abort_prodt", prodt, 0);
    chk64("abort_valid", longint'(valid), 0);
    reset = 1'b1;
    repeat (LAT + 5) @(negedge clock);
    chk64("abort_quiet_prodt", prodt, 0);
    run_op("after_abort", -12345, 6789, -83810205);

    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      run_op($sformatf("rand%0d", i), a, b, longint'(a) * longint'(b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
